// File: rtl/mini_src_mem_pkg.sv
// Shared types and sizes for the Mini-SRC memory responder.
package mini_src_mem_pkg;

    localparam int MEM_ADDR_W = 9;
    localparam int MEM_DATA_W = 32;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/ram_sp.sv
// Synchronous single-port RAM with a registered read port and no array reset.
module ram_sp #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    // Write on we; read the addressed word every cycle (read-before-write on a write cycle)
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: accepts a Read or Write request from MAR/MDR, waits
// WAIT_STATES cycles, performs the access and raises MFC until the request drops.
//
// Handshake: the datapath raises exactly one of Read/Write together with address
// and data_in and holds that request line high until it sees MFC; the request is
// taken in IDLE only, address/data_in are latched there and ignored afterwards.
// MFC stays high while the request is held and falls on the edge after the
// request drops. Dropping the request before MFC aborts the access.
module memory_responder
    import mini_src_mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] Mdatain,
    output logic              MFC,
    output logic              busy,
    output logic              err,
    output logic [1:0]        dbg_state
);

    mem_state_t        state;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        cnt;

    logic              req_held;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // The request line that belongs to the accepted operation
    assign req_held = op_wr ? Write : Read;

    // In IDLE the RAM reads the incoming address so that by the access edge its
    // registered output already holds mem[addr_q]; nothing else writes the array
    // between acceptance and access, so that value is current.
    assign ram_addr = (state == IDLE) ? address : addr_q;

    // Write strobe only in the access cycle of a still-held write
    assign ram_we = (state == BUSY) && op_wr && Write && (cnt == 4'd0);

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    // Request FSM, wait counter, request latches and MFC/err/Mdatain registers
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            MFC     <= 1'b0;
            err     <= 1'b0;
            Mdatain <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (Read ^ Write) begin
                        op_wr  <= Write;
                        addr_q <= address;
                        data_q <= data_in;
                        cnt    <= 4'(WAIT_STATES);
                        state  <= BUSY;
                    end else if (Read && Write) begin
                        err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!req_held) begin
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= DONE;
                        MFC   <= 1'b1;
                        if (!op_wr) begin
                            Mdatain <= ram_rdata;
                        end
                    end
                end
                DONE: begin
                    if (!req_held) begin
                        MFC   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    MFC   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: transaction tasks set the expected outputs from
// the handshake timing rules, a negedge compare process checks every cycle.
module tb_memory_responder;

    localparam int WS = 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    // main DUT (WAIT_STATES = 2)
    logic        rd, wr;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [31:0] mdat;
    logic        mfc, busy, err;
    logic [1:0]  dbg;

    // second DUT (WAIT_STATES = 0)
    logic        r0, w0;
    logic [8:0]  a0;
    logic [31:0] d0;
    logic [31:0] md0;
    logic        mfc0, busy0, err0;
    logic [1:0]  dbg0;

    memory_responder #(.WAIT_STATES(WS)) dut (
        .clock(clock), .clear(clear), .Read(rd), .Write(wr),
        .address(addr), .data_in(din), .Mdatain(mdat), .MFC(mfc),
        .busy(busy), .err(err), .dbg_state(dbg)
    );

    memory_responder #(.WAIT_STATES(0)) dut0 (
        .clock(clock), .clear(clear), .Read(r0), .Write(w0),
        .address(a0), .data_in(d0), .Mdatain(md0), .MFC(mfc0),
        .busy(busy0), .err(err0), .dbg_state(dbg0)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mem_m [int unsigned];

    bit          exp_busy, exp_mfc, exp_err, exp_mfc_d;
    bit          exp_is_read, rd_known, mdat_known, cmp_on;
    logic [31:0] exp_mdat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // One compare process, every cycle
    always @(negedge clock) begin
        if (cmp_on) begin
            if (exp_mfc && !exp_mfc_d && exp_is_read) begin
                if (rd_known) begin
                    chk("rdq_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_mdat   = exp_q.pop_front();
                        mdat_known = 1'b1;
                    end
                end else begin
                    mdat_known = 1'b0;
                end
            end
            exp_mfc_d = exp_mfc;
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("mfc",  32'(mfc),  32'(exp_mfc));
            chk("err",  32'(err),  32'(exp_err));
            if (mdat_known) chk("mdatain", mdat, exp_mdat);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full transaction: request, hold through MFC plus extra cycles, drop, one idle cycle
    task automatic access(input bit is_wr, input logic [8:0] a, input logic [31:0] d, input int extra);
        rd = !is_wr; wr = is_wr; addr = a; din = d;
        tick();                              // acceptance edge
        exp_busy    = 1'b1;
        exp_is_read = !is_wr;
        if (!is_wr) begin
            rd_known = mem_m.exists(a);
            if (rd_known) exp_q.push_back(mem_m[a]);
        end
        addr = a ^ 9'h030;                   // must be ignored after acceptance
        din  = ~d;
        repeat (WS) tick();
        tick();                              // access edge
        exp_mfc = 1'b1;
        if (is_wr) mem_m[a] = d;
        repeat (extra) tick();
        rd = 1'b0; wr = 1'b0;
        tick();
        exp_mfc  = 1'b0;
        exp_busy = 1'b0;
        tick();
    endtask

    // Request dropped after busy_cycles BUSY cycles, before the access happens
    task automatic abort(input bit is_wr, input logic [8:0] a, input logic [31:0] d, input int busy_cycles);
        rd = !is_wr; wr = is_wr; addr = a; din = d;
        tick();
        exp_busy    = 1'b1;
        exp_is_read = !is_wr;
        rd_known    = 1'b0;
        addr = a ^ 9'h030;
        repeat (busy_cycles) tick();
        rd = 1'b0; wr = 1'b0;
        tick();
        exp_busy = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear = 1'b0;
        rd = 1'b1; wr = 1'b0; addr = 9'h033; din = '0;
        r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
        exp_busy = 0; exp_mfc = 0; exp_err = 0; exp_mfc_d = 0;
        exp_is_read = 0; rd_known = 0;
        exp_mdat = '0; mdat_known = 1'b1;
        cmp_on = 1'b1;

        // 1: reset with Read held, then release -> accepted, MFC after WS+1 edges
        repeat (3) tick();
        clear = 1'b1;
        access(1'b0, 9'h033, 32'h0, 0);

        // 2: write then read back
        access(1'b1, 9'h055, 32'h1234_ABCD, 0);
        access(1'b0, 9'h055, 32'h0, 0);
        chk("t2_readback", mdat, 32'h1234_ABCD);

        // 3: both request lines -> err pulse, no access
        rd = 1'b1; wr = 1'b1; addr = 9'h055; din = 32'hFFFF_FFFF;
        tick();
        exp_err = 1'b1;
        rd = 1'b0; wr = 1'b0;
        tick();
        exp_err = 1'b0;
        tick();
        access(1'b0, 9'h055, 32'h0, 0);
        chk("t3_unchanged", mdat, 32'h1234_ABCD);

        // 4: aborted write keeps the old word; aborted read at the last wait cycle
        access(1'b1, 9'h1FF, 32'h0BAD_F00D, 0);
        abort(1'b1, 9'h1FF, 32'hDEAD_BEEF, 1);
        abort(1'b0, 9'h1FF, 32'h0, WS);
        chk("t4_mdat_kept", mdat, 32'h1234_ABCD);
        access(1'b0, 9'h1FF, 32'h0, 0);
        chk("t4_old_value", mdat, 32'h0BAD_F00D);

        // 5: address change during BUSY ignored; MFC held for 5 extra cycles
        access(1'b1, 9'h010, 32'hA5A5_0010, 0);
        access(1'b1, 9'h020, 32'h5A5A_0020, 0);
        access(1'b0, 9'h010, 32'h0, 5);
        chk("t5_latched_addr", mdat, 32'hA5A5_0010);

        // 6: reset mid-BUSY on a write loses the write
        access(1'b1, 9'h077, 32'h7777_0077, 0);
        wr = 1'b1; addr = 9'h077; din = 32'hFEED_0077;
        tick();
        exp_busy = 1'b1;
        tick();
        clear = 1'b0;
        exp_busy = 1'b0; exp_mfc = 1'b0; exp_mdat = '0; mdat_known = 1'b1;
        #1;
        chk("t6_busy_now", 32'(busy), 32'd0);
        chk("t6_mfc_now",  32'(mfc),  32'd0);
        wr = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        access(1'b0, 9'h077, 32'h0, 0);
        chk("t6_word_kept", mdat, 32'h7777_0077);

        // 6b: WAIT_STATES = 0 -> MFC one edge after acceptance
        w0 = 1'b1; a0 = 9'h055; d0 = 32'h1234_ABCD;
        tick();
        chk("ws0_w_busy", 32'(busy0), 32'd1);
        chk("ws0_w_mfc0", 32'(mfc0),  32'd0);
        tick();
        chk("ws0_w_mfc1", 32'(mfc0),  32'd1);
        w0 = 1'b0;
        tick();
        chk("ws0_w_drop", 32'(mfc0),  32'd0);
        tick();
        r0 = 1'b1;
        tick();
        chk("ws0_r_mfc0", 32'(mfc0),  32'd0);
        tick();
        chk("ws0_r_mfc1", 32'(mfc0),  32'd1);
        chk("ws0_r_data", md0, 32'h1234_ABCD);
        r0 = 1'b0;
        tick();
        chk("ws0_r_drop", 32'(mfc0),  32'd0);
        chk("ws0_err",    32'(err0),  32'd0);

        tick();
        cmp_on = 1'b0;
        chk("rdq_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
